// File: rtl/burst_reorder_buffer.sv
// burst_reorder_buffer: accepts in-order AXI-style read bursts, forwards them
// downstream tagged with a slot index, collects out-of-order R beats per slot
// and streams them back upstream in AR order with the original ID.
module burst_reorder_buffer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int ID_WIDTH   = 4,
    parameter  int DEPTH      = 8,
    parameter  int MAX_LEN    = 4,
    localparam int SLOT_W     = $clog2(DEPTH),
    localparam int LEN_W      = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic [LEN_W-1:0]      s_arlen_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rlast_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    output logic [SLOT_W-1:0]     m_arid_o,
    output logic [LEN_W-1:0]      m_arlen_o,
    output logic                  m_arvalid_o,
    input  logic                  m_arready_i,
    input  logic [DATA_WIDTH-1:0] m_rdata_i,
    input  logic [SLOT_W-1:0]     m_rid_i,
    input  logic                  m_rlast_i,
    input  logic                  m_rvalid_i,
    output logic                  m_rready_o,
    output logic                  protocol_err_o
);

    logic [SLOT_W-1:0]     head;
    logic [SLOT_W-1:0]     tail;
    logic [SLOT_W:0]       count;
    logic [LEN_W-1:0]      rd_cnt;
    logic [DEPTH-1:0]      alloc;
    logic [DEPTH-1:0]      closed;
    logic [ID_WIDTH-1:0]   slot_id  [DEPTH];
    logic [LEN_W-1:0]      slot_len [DEPTH];
    logic [LEN_W:0]        wr_cnt   [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH*MAX_LEN];

    logic             full;
    logic             ar_fire;
    logic             r_fire;
    logic             r_ok;
    logic [LEN_W-1:0] r_idx;
    logic             rd_fire;
    logic             rd_done;

    // Handshake decode and combinational outputs; rst_n gates the ready/valid
    // terms so they read 0 while reset is held.
    always_comb begin
        full        = (count == (SLOT_W+1)'(DEPTH));
        m_arvalid_o = rst_n & s_arvalid_i & ~full;
        s_arready_o = rst_n & m_arready_i & ~full;
        m_arid_o    = tail;
        m_arlen_o   = s_arlen_i;
        m_rready_o  = rst_n;

        ar_fire = s_arvalid_i & s_arready_o;
        r_fire  = m_rvalid_i & m_rready_o;
        r_ok    = alloc[m_rid_i] & ~closed[m_rid_i];
        r_idx   = wr_cnt[m_rid_i][LEN_W-1:0];

        s_rvalid_o = alloc[head] & ({1'b0, rd_cnt} < wr_cnt[head]);
        s_rid_o    = slot_id[head];
        s_rdata_o  = s_rvalid_o ? data_mem[{head, rd_cnt}] : '0;
        s_rlast_o  = s_rvalid_o & (rd_cnt == slot_len[head]);

        rd_fire = s_rvalid_o & s_rready_i;
        rd_done = rd_fire & s_rlast_o;
    end

    // Slot bookkeeping, pointers, occupancy and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            rd_cnt         <= '0;
            alloc          <= '0;
            closed         <= '0;
            protocol_err_o <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                slot_id[i]  <= '0;
                slot_len[i] <= '0;
                wr_cnt[i]   <= '0;
            end
        end else begin
            // Ingress: an accepted beat only ever targets an allocated, open
            // slot, which can be neither the slot being freed nor the one
            // being allocated this cycle, so the updates below never collide.
            if (r_fire) begin
                if (r_ok) begin
                    wr_cnt[m_rid_i] <= wr_cnt[m_rid_i] + (LEN_W+1)'(1);
                    if (m_rlast_i || (r_idx == slot_len[m_rid_i])) begin
                        closed[m_rid_i]   <= 1'b1;
                        slot_len[m_rid_i] <= r_idx;
                    end
                end else begin
                    protocol_err_o <= 1'b1;
                end
            end

            if (rd_fire) begin
                if (s_rlast_o) begin
                    alloc[head] <= 1'b0;
                    head        <= head + SLOT_W'(1);
                    rd_cnt      <= '0;
                end else begin
                    rd_cnt <= rd_cnt + LEN_W'(1);
                end
            end

            if (ar_fire) begin
                alloc[tail]    <= 1'b1;
                closed[tail]   <= 1'b0;
                slot_id[tail]  <= s_arid_i;
                slot_len[tail] <= s_arlen_i;
                wr_cnt[tail]   <= '0;
                tail           <= tail + SLOT_W'(1);
            end

            case ({ar_fire, rd_done})
                2'b10:   count <= count + (SLOT_W+1)'(1);
                2'b01:   count <= count - (SLOT_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Beat storage, deliberately left unreset.
    always_ff @(posedge clk) begin
        if (r_fire && r_ok) begin
            data_mem[{m_rid_i, r_idx}] <= m_rdata_i;
        end
    end

endmodule

// File: tb/tb_burst_reorder_buffer.sv
// Testbench for burst_reorder_buffer: directed scenarios plus randomized
// traffic, checked by a scoreboard fed from a per-slot transaction model.
module tb_burst_reorder_buffer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] s_arid_i = '0;
    logic [1:0] s_arlen_i = '0;
    logic       s_arvalid_i = 1'b0;
    logic       s_arready_o;
    logic [7:0] s_rdata_o;
    logic [3:0] s_rid_o;
    logic       s_rlast_o;
    logic       s_rvalid_o;
    logic       s_rready_i = 1'b0;
    logic [1:0] m_arid_o;
    logic [1:0] m_arlen_o;
    logic       m_arvalid_o;
    logic       m_arready_i = 1'b1;
    logic [7:0] m_rdata_i = '0;
    logic [1:0] m_rid_i = '0;
    logic       m_rlast_i = 1'b0;
    logic       m_rvalid_i = 1'b0;
    logic       m_rready_o;
    logic       protocol_err_o;

    burst_reorder_buffer #(
        .DATA_WIDTH(8),
        .ID_WIDTH  (4),
        .DEPTH     (DEPTH),
        .MAX_LEN   (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_arid_i      (s_arid_i),
        .s_arlen_i     (s_arlen_i),
        .s_arvalid_i   (s_arvalid_i),
        .s_arready_o   (s_arready_o),
        .s_rdata_o     (s_rdata_o),
        .s_rid_o       (s_rid_o),
        .s_rlast_o     (s_rlast_o),
        .s_rvalid_o    (s_rvalid_o),
        .s_rready_i    (s_rready_i),
        .m_arid_o      (m_arid_o),
        .m_arlen_o     (m_arlen_o),
        .m_arvalid_o   (m_arvalid_o),
        .m_arready_i   (m_arready_i),
        .m_rdata_i     (m_rdata_i),
        .m_rid_i       (m_rid_i),
        .m_rlast_i     (m_rlast_i),
        .m_rvalid_i    (m_rvalid_i),
        .m_rready_o    (m_rready_o),
        .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
        logic       last;
    } beat_t;

    // Reference model: transactions in AR order, and per slot the beats
    // received but not yet delivered upstream.
    beat_t       exp_q [DEPTH][$];
    int unsigned ar_order[$];
    bit          slot_alloc  [DEPTH];
    bit          slot_closed [DEPTH];
    int          slot_len    [DEPTH];
    int          slot_wr     [DEPTH];
    logic [3:0]  slot_idv    [DEPTH];
    int          tail_slot;
    bit          perr_exp;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        ar_order.delete();
        for (int s = 0; s < DEPTH; s++) begin
            exp_q[s].delete();
            slot_alloc[s]  = 1'b0;
            slot_closed[s] = 1'b0;
            slot_len[s]    = 0;
            slot_wr[s]     = 0;
            slot_idv[s]    = '0;
        end
        tail_slot = 0;
        perr_exp  = 1'b0;
    endtask

    task automatic model_beat(input int r, input logic [7:0] d, input bit rl);
        bit last;
        if (slot_alloc[r] && !slot_closed[r]) begin
            last = rl || (slot_wr[r] == slot_len[r]);
            exp_q[r].push_back('{id: slot_idv[r], data: d, last: last});
            slot_wr[r]++;
            if (last) slot_closed[r] = 1'b1;
        end else begin
            perr_exp = 1'b1;
        end
    endtask

    // Asserts reset away from any clock edge, checks reset values, releases.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        s_arvalid_i = 1'b1;
        m_arready_i = 1'b1;
        s_arlen_i   = 2'd2;
        m_rvalid_i  = 1'b0;
        s_rready_i  = 1'b1;
        #1;
        chk("rst_s_arready", s_arready_o, 0);
        chk("rst_m_arvalid", m_arvalid_o, 0);
        chk("rst_s_rvalid", s_rvalid_o, 0);
        chk("rst_s_rlast", s_rlast_o, 0);
        chk("rst_m_rready", m_rready_o, 0);
        chk("rst_perr", protocol_err_o, 0);
        chk("rst_s_rdata", s_rdata_o, 0);
        chk("rst_s_rid", s_rid_o, 0);
        chk("rst_m_arid", m_arid_o, 0);
        chk("rst_m_arlen", m_arlen_o, 2);
        s_arvalid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic step(input bit arv, input logic [3:0] arid, input logic [1:0] arlen,
                        input bit rv, input logic [1:0] rid, input logic [7:0] rdata,
                        input bit rlast, input bit rrdy);
        bit ar_fire;
        bit exp_rdy;
        s_arvalid_i = arv;
        s_arid_i    = arid;
        s_arlen_i   = arlen;
        m_rvalid_i  = rv;
        m_rid_i     = rid;
        m_rdata_i   = rdata;
        m_rlast_i   = rlast;
        s_rready_i  = rrdy;
        #3;
        exp_rdy = m_arready_i && (ar_order.size() < DEPTH);
        ar_fire = arv && s_arready_o;
        chk("m_arlen", m_arlen_o, arlen);
        if (arv) begin
            chk("s_arready", s_arready_o, exp_rdy);
            chk("m_arvalid", m_arvalid_o, ar_order.size() < DEPTH);
            chk("m_arid", m_arid_o, tail_slot);
        end
        @(posedge clk);
        if (rv) model_beat(rid, rdata, rlast);
        if (ar_fire) begin
            slot_alloc[tail_slot]  = 1'b1;
            slot_closed[tail_slot] = 1'b0;
            slot_idv[tail_slot]    = arid;
            slot_len[tail_slot]    = arlen;
            slot_wr[tail_slot]     = 0;
            ar_order.push_back(tail_slot);
            tail_slot = (tail_slot + 1) % DEPTH;
        end
        #1;
        m_rvalid_i  = 1'b0;
        s_arvalid_i = 1'b0;
    endtask

    task automatic idle(input bit rrdy);
        step(1'b0, 4'd0, 2'd0, 1'b0, 2'd0, 8'd0, 1'b0, rrdy);
    endtask

    // Scoreboard monitor: compares the upstream R channel with the model on
    // every falling edge and retires beats that handshake on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit          ev;
                int unsigned h;
                beat_t       b;
                ev = (ar_order.size() > 0) && (exp_q[ar_order[0]].size() > 0);
                chk("s_rvalid", s_rvalid_o, ev);
                chk("protocol_err", protocol_err_o, perr_exp);
                chk("m_rready", m_rready_o, 1);
                if (ev && s_rvalid_o) begin
                    h = ar_order[0];
                    b = exp_q[h][0];
                    chk("s_rid", s_rid_o, b.id);
                    chk("s_rdata", s_rdata_o, b.data);
                    chk("s_rlast", s_rlast_o, b.last);
                    if (s_rready_i) begin
                        void'(exp_q[h].pop_front());
                        if (b.last) begin
                            slot_alloc[h] = 1'b0;
                            void'(ar_order.pop_front());
                        end
                    end
                end else if (!s_rvalid_o) begin
                    chk("s_rdata_idle", s_rdata_o, 0);
                end
            end
        end
    end

    initial begin
        int unsigned open_s[$];
        logic [1:0]  rid;
        bit          rv;
        bit          rl;
        int          guard;

        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Single beat
        step(1'b1, 4'd4, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 8'h11, 1'b1, 1'b0);
        chk("single_valid", s_rvalid_o, 1);
        chk("single_rid", s_rid_o, 4);
        chk("single_data", s_rdata_o, 8'h11);
        chk("single_last", s_rlast_o, 1);
        idle(1'b1);
        idle(1'b1);

        // Reorder
        do_reset();
        step(1'b1, 4'd4, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 4'd7, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd1, 8'h22, 1'b1, 1'b1);
        chk("reorder_hold", s_rvalid_o, 0);
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 8'h33, 1'b1, 1'b1);
        chk("reorder_first_rid", s_rid_o, 4);
        chk("reorder_first_data", s_rdata_o, 8'h33);
        idle(1'b1);
        chk("reorder_second_rid", s_rid_o, 7);
        chk("reorder_second_data", s_rdata_o, 8'h22);
        idle(1'b1);
        idle(1'b1);

        // Cut-through burst
        step(1'b1, 4'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 4'd0, 2'd0, 1'b1, 2'(m_arid_o - 2'd1), 8'(8'hA0 + k), k == 3, 1'b1);
            chk("ct_valid", s_rvalid_o, 1);
            chk("ct_data", s_rdata_o, 8'hA0 + k);
            chk("ct_last", s_rlast_o, k == 3);
            idle(1'b1);
            chk("ct_gap", s_rvalid_o, 0);
        end

        // Full and wrap
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 4'(k + 1), 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 4'd5, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 4'd5, 2'd0, 1'b1, 2'd0, 8'h61, 1'b1, 1'b0);
        step(1'b1, 4'd5, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 4'd5, 2'd0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        chk("wrap_accepted", ar_order.size(), 4);
        chk("wrap_tail", tail_slot, 1);

        // Protocol error
        do_reset();
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd3, 8'h55, 1'b1, 1'b1);
        chk("perr_set", protocol_err_o, 1);
        chk("perr_no_rvalid", s_rvalid_o, 0);
        repeat (3) idle(1'b1);
        chk("perr_sticky", protocol_err_o, 1);

        // Backpressure, then reset mid-burst
        do_reset();
        step(1'b1, 4'd2, 2'd3, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 8'hA0, 1'b0, 1'b1);
        idle(1'b1);
        step(1'b0, 4'd0, 2'd0, 1'b1, 2'd0, 8'hA1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            idle(1'b0);
            chk("bp_valid", s_rvalid_o, 1);
            chk("bp_data", s_rdata_o, 8'hA1);
            chk("bp_rid", s_rid_o, 2);
            chk("bp_last", s_rlast_o, 0);
        end
        #2;
        do_reset();
        step(1'b1, 4'd9, 2'd1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
        chk("post_rst_accept", ar_order.size(), 1);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            m_arready_i = ($urandom_range(3) != 0);
            open_s.delete();
            for (int s = 0; s < DEPTH; s++)
                if (slot_alloc[s] && !slot_closed[s]) open_s.push_back(s);
            rv = 1'b0;
            rid = '0;
            if ($urandom_range(59) == 0) begin
                rv  = 1'b1;
                rid = 2'($urandom_range(3));
            end else if (open_s.size() > 0 && $urandom_range(3) != 0) begin
                rv  = 1'b1;
                rid = 2'(open_s[$urandom_range(open_s.size() - 1)]);
            end
            rl = ($urandom_range(7) == 0);
            step($urandom_range(1) == 1, 4'($urandom), 2'($urandom), rv, rid,
                 8'($urandom), rl, $urandom_range(3) != 0);
        end

        // Drain whatever is still outstanding
        m_arready_i = 1'b1;
        guard = 0;
        while (ar_order.size() > 0 && guard < 400) begin
            open_s.delete();
            for (int s = 0; s < DEPTH; s++)
                if (slot_alloc[s] && !slot_closed[s]) open_s.push_back(s);
            if (open_s.size() > 0)
                step(1'b0, 4'd0, 2'd0, 1'b1, 2'(open_s[0]), 8'($urandom), 1'b0, 1'b1);
            else
                idle(1'b1);
            guard++;
        end
        chk("drain_done", ar_order.size(), 0);
        idle(1'b1);
        chk("drain_idle", s_rvalid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
